// File: rtl/alu_seq_shifter.sv
`timescale 1ns/1ps
// alu_seq_shifter: bit-serial shift/rotate unit for the ALU result mux.
// Shifts a captured operand by one bit per clock under a start/busy/done
// handshake so the control FSM can stall the pipeline.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             request pulse, accepted in IDLE or DONE
//   op                00=SLL 01=SRL 10=SRA 11=ROR
//   operand_a, shamt  value and shift amount, captured on acceptance
//   busy              high while shifting
//   done              one-cycle completion pulse
//   result, carry     shifted value and last bit shifted/rotated out
module alu_seq_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_d;
  logic             carry_d, busy_d, done_d;
  logic [WIDTH-1:0] step_val;
  logic             step_carry;

  // One-bit shift/rotate of the work register for the latched op.
  always_comb begin
    step_val   = work_q;
    step_carry = 1'b0;
    case (op_q)
      OP_SLL: begin
        step_val   = {work_q[WIDTH-2:0], 1'b0};
        step_carry = work_q[WIDTH-1];
      end
      OP_SRL: begin
        step_val   = {1'b0, work_q[WIDTH-1:1]};
        step_carry = work_q[0];
      end
      OP_SRA: begin
        step_val   = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        step_carry = work_q[0];
      end
      default: begin
        step_val   = {work_q[0], work_q[WIDTH-1:1]};
        step_carry = work_q[0];
      end
    endcase
  end

  // Next-state and next-output logic; outputs are registered from *_d.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result;
    carry_d  = carry;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          work_d = operand_a;
          op_d   = op;
          cnt_d  = shamt;
          if (shamt == '0) begin
            // Zero shift completes straight away with the operand untouched.
            state_d  = S_DONE;
            result_d = operand_a;
            carry_d  = 1'b0;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        work_d = step_val;
        cnt_d  = cnt_q - SHW'(1);
        // Last step: publish the final value together with the bit it pushed out.
        if (cnt_q == SHW'(1)) begin
          state_d  = S_DONE;
          result_d = step_val;
          carry_d  = step_carry;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      result  <= '0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      result  <= result_d;
      carry   <= carry_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule
